// File: rtl/xs3_to_bcd_serial.sv
// Bit-serial excess-3 to BCD decoder (subtracts 0011 LSB first) with digit/error counters.
// Latency: 1 cycle per bit; parallel digit and code_err pulse with the final serial bit.
// Backpressure: none; in_valid=0 stalls the FSM indefinitely, clr aborts a partial digit.
module xs3_to_bcd_serial #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             out_valid,
    output logic             out_bit,
    output logic             digit_valid,
    output logic [3:0]       bcd_digit,
    output logic             code_err,
    output logic [CNT_W-1:0] digit_count,
    output logic [CNT_W-1:0] err_count
);

    // State suffix carries the borrow into the next bit position.
    typedef enum logic [2:0] {
        S_B0,
        S_B1_NB,
        S_B1_B,
        S_B2_NB,
        S_B2_B,
        S_B3_NB,
        S_B3_B
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cap_q, cap_d;
    logic             out_valid_q, out_valid_d;
    logic             out_bit_q, out_bit_d;
    logic             digit_valid_q, digit_valid_d;
    logic [3:0]       bcd_digit_q, bcd_digit_d;
    logic             code_err_q, code_err_d;
    logic [CNT_W-1:0] digit_count_q, digit_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic       borrow_in;
    logic       diff;
    logic       borrow_out;
    logic [3:0] code;

    always_comb begin
        state_d       = state_q;
        cap_d         = cap_q;
        out_valid_d   = 1'b0;
        out_bit_d     = out_bit_q;
        digit_valid_d = 1'b0;
        bcd_digit_d   = bcd_digit_q;
        code_err_d    = 1'b0;
        digit_count_d = digit_count_q;
        err_count_d   = err_count_q;

        borrow_in = (state_q == S_B1_B) || (state_q == S_B2_B) || (state_q == S_B3_B);
        code      = {in_bit, cap_q};

        // Subtrahend bits are 1,1,0,0 so each position reduces to a fixed form.
        case (state_q)
            S_B0: begin
                diff       = ~in_bit;
                borrow_out = ~in_bit;
            end
            S_B1_NB, S_B1_B: begin
                diff       = ~in_bit ^ borrow_in;
                borrow_out = ~in_bit | borrow_in;
            end
            default: begin
                diff       = in_bit ^ borrow_in;
                borrow_out = ~in_bit & borrow_in;
            end
        endcase

        if (clr) begin
            state_d = S_B0;
            cap_d   = 3'b000;
        end else if (in_valid) begin
            out_valid_d = 1'b1;
            out_bit_d   = diff;
            case (state_q)
                S_B0: begin
                    cap_d[0] = in_bit;
                    state_d  = borrow_out ? S_B1_B : S_B1_NB;
                end
                S_B1_NB, S_B1_B: begin
                    cap_d[1] = in_bit;
                    state_d  = borrow_out ? S_B2_B : S_B2_NB;
                end
                S_B2_NB, S_B2_B: begin
                    cap_d[2] = in_bit;
                    state_d  = borrow_out ? S_B3_B : S_B3_NB;
                end
                default: begin
                    state_d       = S_B0;
                    digit_valid_d = 1'b1;
                    bcd_digit_d   = code - 4'd3;
                    // Final borrow means code < 3.
                    code_err_d    = borrow_out || (code > 4'd12);
                    digit_count_d = digit_count_q + 1'b1;
                    if (code_err_d) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_B0;
            cap_q         <= 3'b000;
            out_valid_q   <= 1'b0;
            out_bit_q     <= 1'b0;
            digit_valid_q <= 1'b0;
            bcd_digit_q   <= 4'b0000;
            code_err_q    <= 1'b0;
            digit_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            cap_q         <= cap_d;
            out_valid_q   <= out_valid_d;
            out_bit_q     <= out_bit_d;
            digit_valid_q <= digit_valid_d;
            bcd_digit_q   <= bcd_digit_d;
            code_err_q    <= code_err_d;
            digit_count_q <= digit_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_bit     = out_bit_q;
    assign digit_valid = digit_valid_q;
    assign bcd_digit   = bcd_digit_q;
    assign code_err    = code_err_q;
    assign digit_count = digit_count_q;
    assign err_count   = err_count_q;

endmodule

// File: doc/xs3_to_bcd_serial.md
Name: xs3_to_bcd_serial

Overview:
Bit-serial excess-3 to BCD decoder. It is the inverse of the team's BCD-to-excess-3 code converter.
- Accepts one excess-3 digit as 4 bits, LSB first, one bit per accepted cycle.
- Emits the BCD result serially with 1-cycle latency, plus a parallel digit at each digit boundary.
- Flags codes outside the excess-3 range (3..12) and keeps digit/error counters for the datapath status block.

Parameters:
CNT_W, 8, width of digit_count and err_count (both wrap modulo 2^CNT_W)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous abort: drop any partial digit, return to bit 0; counters unchanged
in_valid  input  1  in_bit is valid this cycle and is consumed
in_bit  input  1  excess-3 serial data, LSB first
out_valid  output  1  out_bit valid (registered)
out_bit  output  1  BCD serial data, LSB first (registered)
digit_valid  output  1  1-cycle pulse: bcd_digit/code_err valid
bcd_digit  output  4  parallel result, (code - 3) mod 16
code_err  output  1  qualifies digit_valid: input code < 3 or > 12
digit_count  output  CNT_W  digits completed since reset
err_count  output  CNT_W  digits flagged code_err since reset

Behaviour:
- Reset (async, rst_n=0): FSM to S_B0; borrow=0; capture reg=0; all outputs 0 (out_valid, out_bit, digit_valid, bcd_digit, code_err, digit_count, err_count). Reset mid-digit discards the partial digit.
- Serial subtraction of constant 0011, bit i with subtrahend s_i (s0=s1=1, s2=s3=0), input x, borrow b:
  - diff = x^s_i^b
  - b' = (~x&(s_i|b)) | (s_i&b)
  - Bit 0: diff=~x, b'=~x.
  - Bit 1: diff=~x^b, b'=~x|b.
  - Bits 2 and 3: diff=x^b, b'=~x&b.
- FSM states: S_B0, S_B1_NB, S_B1_B, S_B2_NB, S_B2_B, S_B3_NB, S_B3_B. The suffix is the borrow carried in.
  - Advance only on in_valid=1.
  - From S_B3_*: go to S_B0 (digit complete).
  - in_valid=0: state, borrow and capture hold. out_valid=0 next cycle. Stalls of any length are legal.
- Latency: the bit accepted at edge N gives out_valid=1 and out_bit=diff after edge N, i.e. valid during cycle N+1. Back-to-back input gives a continuous output stream.
- Capture register keeps the 4 input bits. On the edge accepting bit 3, all of the following happen together:
  - digit_valid=1 for exactly one cycle, coincident with the final out_bit.
  - bcd_digit=(code-3)[3:0], which equals the 4 emitted bits.
  - code_err=1 iff code<3 (final borrow=1) or code>12.
  - digit_count+=1 always.
  - err_count+=1 iff code_err.
- Outside digit_valid, code_err=0. bcd_digit holds its last value.
- Counters wrap: 2^CNT_W-1 -> 0, no saturation, no flag.
- clr=1: takes priority over in_valid that cycle.
  - State goes to S_B0, borrow and capture clear.
  - No out_valid and no digit_valid are produced for that cycle's bit.
  - Counters hold.
  - clr with no partial digit is a no-op.
- Digits are back-to-back capable: bit 0 of the next digit may be accepted the cycle after bit 3.

Test Plan:
- Reset, then bits 1,1,0,0 (code 0011) continuous -> out bits 0,0,0,0 one cycle later; digit_valid pulse with bcd_digit=0000, code_err=0, digit_count=1.
- All codes 0011..1100 back-to-back, 40 consecutive valid cycles -> bcd_digit 0..9 in order; 10 digit_valid pulses 4 cycles apart; err_count=0; digit_count=10.
- Code 0000, then code 1111 -> bcd_digit 1101 with code_err=1, then 1100 with code_err=1; err_count=2; serial bits match bcd_digit LSB first.
- Code 1000 (BCD 5) with 3 idle in_valid=0 cycles between each bit -> out_valid only after accepted bits; out bits 1,0,1,0; one digit_valid, bcd_digit=0101.
- clr asserted after 2 bits of 0111, then full 0100 -> no digit_valid for the aborted digit; next digit bcd_digit=0001; digit_count increments by 1 only.
- rst_n dropped asynchronously mid-digit (between edges) -> all outputs 0 immediately; following digit 1001 decodes to 0110; CNT_W=2 run of 5 digits -> digit_count wraps to 1.
